ofs_plat_axi_mem_ram_responder: RTL and testbench
=================================================

OFS_PLAT_AXI_MEM_RAM_RESPONDER -- requirements
Module: ofs_plat_axi_mem_ram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte address width of AW/AR addr.
REQ-002 Parameter DATA_WIDTH, default 64: W/R data width in bits; power of 2, at least 8.
REQ-003 Parameter ID_WIDTH, default 4: width of awid/bid/arid/rid.
REQ-004 Parameter DEPTH_LOG2, default 10: the RAM holds 2^DEPTH_LOG2 words of DATA_WIDTH bits.
REQ-005 Ports: clk in 1 (sole clock); reset in 1 (synchronous, active-high).
REQ-006 AW: awvalid in 1; awready out 1; awaddr in ADDR_WIDTH; awid in ID_WIDTH; awlen in 8 (beats-1).
REQ-007 W: wvalid in 1; wready out 1; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1.
REQ-008 B: bvalid out 1; bready in 1; bid out ID_WIDTH; bresp out 2.
REQ-009 AR: arvalid in 1; arready out 1; araddr in ADDR_WIDTH; arid in ID_WIDTH; arlen in 8.
REQ-010 R: rvalid out 1; rready in 1; rdata out DATA_WIDTH; rid out ID_WIDTH; rresp out 2; rlast out 1.

Function
REQ-011 Sink end of an AXI memory channel set: it terminates AW/W/AR and sources B/R; a transfer completes on a valid&&ready cycle.
REQ-012 Burst type: INCR only. Word index = addr[log2(DATA_WIDTH/8) +: DEPTH_LOG2], plus 1 per beat, wrapping modulo 2^DEPTH_LOG2; upper address bits are ignored.
REQ-013 Write FSM: WR_IDLE -> WR_DATA on AW handshake (latch id, index, awlen); WR_DATA -> WR_RESP on acceptance of beat awlen+1; WR_RESP -> WR_IDLE on B handshake.
REQ-014 awready=1 only in WR_IDLE; wready=1 only in WR_DATA. W beats arriving before AW are held off.
REQ-015 Each accepted W beat writes only the bytes whose wstrb bit is 1; the write is visible to reads starting the next cycle.
REQ-016 Exactly awlen+1 W beats are consumed. If wlast differs from (beat==awlen) on any beat, bresp=2'b10 (SLVERR); otherwise 2'b00 (OKAY). Memory is written regardless.
REQ-017 bvalid=1 only in WR_RESP, with bid = latched awid. bvalid stays high with stable bid/bresp until bready.
REQ-018 Read FSM: RD_IDLE -> RD_BURST on AR handshake; RD_BURST -> RD_IDLE on the R handshake with rlast=1. arready=1 only in RD_IDLE.
REQ-019 Read latency: the first rvalid is asserted in the cycle after the AR handshake. Back-to-back beats occur at 1 per cycle while rready=1.
REQ-020 rdata/rid/rlast/rresp are held stable while rvalid&&!rready. rresp is always 2'b00. rid = arid. rlast=1 on beat arlen only.
REQ-021 Read and write FSMs are independent and run concurrently. A same-cycle read of a word being written returns the old contents (read-first).
REQ-022 awlen=0 and arlen=0 are single-beat bursts. awlen=255 and arlen=255 are full 256-beat bursts with index wrap per REQ-012.

Reset
REQ-023 While reset=1: both FSMs go to IDLE; awready, wready, bvalid, arready, rvalid and rlast are 0. awready and arready become 1 in the first cycle after reset deasserts.
REQ-024 Reset mid-burst abandons the burst with no B or R response. RAM contents are not cleared and are undefined from power-up.

Structure
REQ-025 AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the FSM state enums are defined in package ofs_plat_axi_mem_responder_pkg.
REQ-026 Storage is one sub-module, ofs_plat_prim_ram_be_1r1w: one read port and one byte-enable write port, registered read, read-first.

Verification
REQ-027 Write awaddr=0x40, awlen=3, 4 beats 0x11..0x44, full strobes, wlast on beat 3 -> bresp=00 and bid=awid. Read araddr=0x40, arlen=3 -> 0x11..0x44, rlast on beat 3 only.
REQ-028 Write wstrb=0x01 with wdata=0xFF over word 0x0 -> a later read returns 0xFF only in byte 0; all other bytes unchanged.
REQ-029 awlen=1 with wlast asserted on beat 0 -> two beats consumed, bresp=2'b10.
REQ-030 rready toggled randomly during a 16-beat read -> no beat lost or duplicated; R fields stable while stalled. bready held 0 for 10 cycles -> bvalid held and awready=0.
REQ-031 Read to the last RAM word with arlen=1 -> beat 1 returns word 0 (wrap).
REQ-032 Reset asserted during beat 2 of a 4-beat read -> rvalid=0 next cycle; arready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ofs_plat_axi_mem_responder_pkg.sv
// Shared AXI response codes and FSM state encodings for the RAM-backed AXI memory responder.
package ofs_plat_axi_mem_responder_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/ofs_plat_prim_ram_be_1r1w.sv
// Simple dual-port RAM: one registered read port, one byte-enable write port, read-first.
module ofs_plat_prim_ram_be_1r1w #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rd_en,
  input  logic [DEPTH_LOG2-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data_p1,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  // Read output holds when rd_en is low so the responder can stall without re-reading.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_p1 <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ofs_plat_axi_mem_ram_responder.sv
// AXI memory sink backed by a local RAM: independent INCR write and read burst engines.
module ofs_plat_axi_mem_ram_responder
  import ofs_plat_axi_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [7:0]              awlen,

  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,

  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,

  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [7:0]              arlen,

  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [1:0]              rresp,
  output logic                    rlast
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);

  wr_state_t               wr_state;
  rd_state_t               rd_state;
  logic [ID_WIDTH-1:0]     wr_id, rd_id;
  logic [DEPTH_LOG2-1:0]   wr_idx, rd_idx;
  logic [7:0]              wr_len, wr_beat, rd_len, rd_beat;
  logic                    wr_err;
  logic                    aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [DEPTH_LOG2-1:0]   ar_idx, ram_rd_addr;
  logic                    ram_rd_en;
  logic [DATA_WIDTH-1:0]   rd_data_p1;
  logic                    unused_addr_bits;

  assign unused_addr_bits = &{1'b0, awaddr, araddr};
  assign ar_idx = araddr[OFF_W +: DEPTH_LOG2];

  // Handshake-facing flags are masked by reset so they read 0 for the whole reset window.
  assign awready = !reset && (wr_state == WR_IDLE);
  assign wready  = !reset && (wr_state == WR_DATA);
  assign bvalid  = !reset && (wr_state == WR_RESP);
  assign arready = !reset && (rd_state == RD_IDLE);
  assign rvalid  = !reset && (rd_state == RD_BURST);

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign b_fire  = bvalid && bready;
  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;

  assign bid   = wr_id;
  assign bresp = wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign rid   = rd_id;
  assign rresp = AXI_RESP_OKAY;
  assign rlast = rvalid && (rd_beat == rd_len);
  assign rdata = rd_data_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
    end else begin
      case (wr_state)
        WR_IDLE: if (aw_fire) wr_state <= WR_DATA;
        WR_DATA: if (w_fire && (wr_beat == wr_len)) wr_state <= WR_RESP;
        WR_RESP: if (b_fire) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // A wlast/beat-count disagreement only flags SLVERR; the beat is still written.
  always_ff @(posedge clk) begin
    if (aw_fire) begin
      wr_id   <= awid;
      wr_idx  <= awaddr[OFF_W +: DEPTH_LOG2];
      wr_len  <= awlen;
      wr_beat <= 8'd0;
      wr_err  <= 1'b0;
    end else if (w_fire) begin
      wr_idx  <= wr_idx + DEPTH_LOG2'(1);
      wr_beat <= wr_beat + 8'd1;
      if (wlast != (wr_beat == wr_len)) wr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
    end else begin
      case (rd_state)
        RD_IDLE:  if (ar_fire) rd_state <= RD_BURST;
        RD_BURST: if (r_fire && rlast) rd_state <= RD_IDLE;
        default:  rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ar_fire) begin
      rd_id   <= arid;
      rd_idx  <= ar_idx;
      rd_len  <= arlen;
      rd_beat <= 8'd0;
    end else if (r_fire) begin
      rd_idx  <= rd_idx + DEPTH_LOG2'(1);
      rd_beat <= rd_beat + 8'd1;
    end
  end

  // Prefetch the next beat only when the current one is consumed; a stall leaves RAM output held.
  assign ram_rd_en   = ar_fire || (r_fire && !rlast);
  assign ram_rd_addr = ar_fire ? ar_idx : rd_idx + DEPTH_LOG2'(1);

  ofs_plat_prim_ram_be_1r1w #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) ram (
    .clk        (clk),
    .rd_en      (ram_rd_en),
    .rd_addr    (ram_rd_addr),
    .rd_data_p1 (rd_data_p1),
    .wr_en      (w_fire),
    .wr_addr    (wr_idx),
    .wr_data    (wdata),
    .wr_be      (wstrb)
  );

endmodule

// File: tb/tb_ofs_plat_axi_mem_ram_responder.sv
// Directed-plus-random bench for the AXI RAM responder with a word-array memory model.
module tb_ofs_plat_axi_mem_ram_responder;

  localparam int WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic        wvalid = 0, wready;
  logic [63:0] wdata = 0;
  logic [7:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready = 0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic        rvalid, rready = 0;
  logic [63:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl [WORDS];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic        wl [256];

  always #5 clk = ~clk;

  ofs_plat_axi_mem_ram_responder #(
    .ADDR_WIDTH (32), .DATA_WIDTH (64), .ID_WIDTH (4), .DEPTH_LOG2 (6)
  ) dut (
    .clk (clk), .reset (reset),
    .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awid (awid), .awlen (awlen),
    .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb), .wlast (wlast),
    .bvalid (bvalid), .bready (bready), .bid (bid), .bresp (bresp),
    .arvalid (arvalid), .arready (arready), .araddr (araddr), .arid (arid), .arlen (arlen),
    .rvalid (rvalid), .rready (rready), .rdata (rdata), .rid (rid), .rresp (rresp), .rlast (rlast)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word index of beat b: address bits [8:3] plus the beat number, modulo the RAM depth.
  function automatic int mi(input logic [31:0] a, input int b);
    return (int'(a[8:3]) + b) % WORDS;
  endfunction

  // Random address whose index bits select word w; unrelated bits are scrambled.
  function automatic logic [31:0] mkaddr(input int w);
    return ($urandom & 32'hFFFF_FE07) | (32'(w % WORDS) << 3);
  endfunction

  task automatic set_beats(input int len, input bit full, input int badlast);
    for (int i = 0; i <= len; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = full ? 8'hFF : 8'($urandom);
      wl[i] = (i == len) ^ (i == badlast);
    end
  endtask

  task automatic write_burst(input logic [31:0] a, input int len, input logic [3:0] id,
                             input int bdelay, input bit gaps);
    int to;
    bit err, tmo;
    logic [1:0] exp_resp;
    err = 0;
    tmo = 0;
    awaddr = a; awid = id; awlen = 8'(len); awvalid = 1;
    to = 0;
    while (awready !== 1'b1 && to < 50) begin @(negedge clk); to++; end
    if (to >= 50) tmo = 1;
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 0; @(negedge clk); end
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
      to = 0;
      while (wready !== 1'b1 && to < 50) begin @(negedge clk); to++; end
      if (to >= 50) tmo = 1;
      @(negedge clk);
      for (int b = 0; b < 8; b++)
        if (ws[i][b]) mdl[mi(a, i)][8*b +: 8] = wd[i][8*b +: 8];
      if (wl[i] != (i == len)) err = 1;
    end
    wvalid = 0; wlast = 0;
    exp_resp = err ? 2'b10 : 2'b00;
    bready = 0;
    to = 0;
    while (bvalid !== 1'b1 && to < 50) begin @(negedge clk); to++; end
    if (to >= 50) tmo = 1;
    chk("w_timeout", tmo, 0);
    for (int c = 0; c < bdelay; c++) begin
      chk("b_hold", {bvalid, awready, wready, bid, bresp}, {1'b1, 1'b0, 1'b0, id, exp_resp});
      @(negedge clk);
    end
    chk("b_resp", {bvalid, wready, bid, bresp}, {1'b1, 1'b0, id, exp_resp});
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("b_done", {bvalid, awready}, {1'b0, 1'b1});
  endtask

  task automatic read_burst(input logic [31:0] a, input int len, input logic [3:0] id, input bit rnd);
    int to, stall;
    logic rr;
    araddr = a; arid = id; arlen = 8'(len); arvalid = 1;
    to = 0;
    while (arready !== 1'b1 && to < 50) begin @(negedge clk); to++; end
    chk("ar_timeout", to >= 50, 0);
    @(negedge clk);
    arvalid = 0;
    for (int b = 0; b <= len; b++) begin
      stall = 0;
      do begin
        rr = (rnd && stall < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
        rready = rr;
        chk("r_beat", {rvalid, rlast, arready, rid, rresp, rdata},
            {1'b1, 1'(b == len), 1'b0, id, 2'b00, mdl[mi(a, b)]});
        @(negedge clk);
        stall++;
      end while (!rr);
    end
    rready = 0;
    chk("r_done", {rvalid, arready}, {1'b0, 1'b1});
  endtask

  initial begin
    logic [31:0] a, ra;
    int len;

    // Reset window and first cycle afterwards.
    repeat (3) @(negedge clk);
    chk("rst_outs", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    reset = 0;
    @(negedge clk);
    chk("rst_exit", {awready, arready, wready, bvalid, rvalid}, 5'b11000);

    // W without AW is held off.
    wvalid = 1; wdata = 64'hDEAD; wstrb = 8'hFF; wlast = 1;
    for (int c = 0; c < 3; c++) begin
      chk("w_holdoff", wready, 1'b0);
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;

    // Fill the whole RAM so every model word is defined.
    set_beats(WORDS - 1, 1, -1);
    write_burst(32'h0, WORDS - 1, 4'h1, 0, 0);

    // Basic 4-beat write/read at 0x40.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'h11 * (i + 1); ws[i] = 8'hFF; wl[i] = (i == 3);
    end
    write_burst(32'h40, 3, 4'h5, 0, 0);
    read_burst(32'h40, 3, 4'h9, 0);

    // Single-byte strobe on word 0.
    wd[0] = 64'hFF; ws[0] = 8'h01; wl[0] = 1;
    write_burst(32'h0, 0, 4'h2, 0, 0);
    read_burst(32'h0, 0, 4'h3, 0);

    // Early wlast: two beats still consumed, SLVERR reported.
    set_beats(1, 1, 0);
    wl[1] = 1;
    a = mkaddr(20);
    write_burst(a, 1, 4'h6, 0, 0);
    read_burst(a, 1, 4'h7, 0);

    // B backpressure and a 16-beat read with random rready.
    set_beats(15, 0, -1);
    a = mkaddr(40);
    write_burst(a, 15, 4'hC, 10, 1);
    read_burst(a, 15, 4'hD, 1);

    // Read across the top of the RAM wraps to word 0.
    read_burst(32'((WORDS - 1) * 8), 1, 4'hE, 0);

    // Full 256-beat bursts wrap the index several times.
    set_beats(255, 0, -1);
    a = mkaddr($urandom_range(0, WORDS - 1));
    write_burst(a, 255, 4'hF, 1, 1);
    read_burst(a, 255, 4'h0, 1);

    // Random transactions.
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(0, 20);
      set_beats(len, $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1);
      a = mkaddr($urandom_range(0, WORDS - 1));
      write_burst(a, len, 4'($urandom), $urandom_range(0, 3), 1);
      ra = mkaddr($urandom_range(0, WORDS - 1));
      read_burst(ra, $urandom_range(0, 20), 4'($urandom), 1);
    end

    // Concurrent write and read on disjoint regions.
    set_beats(7, 1, -1);
    fork
      write_burst(mkaddr(32), 7, 4'hA, 2, 1);
      read_burst(mkaddr(0), 7, 4'hB, 1);
    join

    // Reset while beat 2 of a 4-beat read is presented.
    ra = mkaddr(10);
    araddr = ra; arid = 4'h3; arlen = 8'd3; arvalid = 1; rready = 1;
    len = 0;
    while (arready !== 1'b1 && len < 50) begin @(negedge clk); len++; end
    @(negedge clk);
    arvalid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_b2", {rvalid, rlast, rdata}, {1'b1, 1'b0, mdl[mi(ra, 2)]});
    reset = 1;
    @(negedge clk);
    chk("rst_mid", {rvalid, rlast, arready, awready, wready, bvalid}, 6'b0);
    @(negedge clk);
    reset = 0; rready = 0;
    @(negedge clk);
    chk("rst_after", {arready, awready, rvalid, bvalid}, 4'b1100);

    // Contents survive reset; engine works again.
    read_burst(ra, 3, 4'h4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
